psum_row_serializer: RTL and testbench
======================================

# psum_row_serializer

Downstream drain stage for the accelerator core. It captures full-width output rows (`col` partial sums of `psum_bw` bits each) whenever the core asserts its output valid, and buffers them in a small row FIFO. It then streams each row one psum word per cycle over a ready/valid interface to the host/readout side. The core has no backpressure, so an overflow is recorded in a sticky flag rather than stalling the core.

## Interface
- `col`, 8, psum words per row; at least 2
- `psum_bw`, 16, bits per psum word
- `depth`, 4, row FIFO entries; power of 2, at least 2

- `clk`  in  1  single clock; everything is on the rising edge
- `reset`  in  1  synchronous, active-low
- `in_valid`  in  1  row-present strobe from the core output valid
- `in_data`  in  psum_bw*col  row from the core output; word k is bits [psum_bw*(k+1)-1 : psum_bw*k]
- `out_ready`  in  1  downstream accepts the current word
- `out_valid`  out  1  a word is presented
- `out_data`  out  psum_bw  current word
- `out_col`  out  max(1,$clog2(col))  index of the current word within its row
- `out_last`  out  1  current word is column col-1
- `full`  out  1  count == depth
- `empty`  out  1  count == 0
- `overflow`  out  1  sticky: a row was dropped

## Operation
- **Storage and state.** The block holds `depth` row registers, plus `wr_ptr`/`rd_ptr` (`$clog2(depth)` bits, wrapping modulo depth), `count` (`$clog2(depth+1)` bits) and a column index `idx` (0..col-1).
- **Push.**
  - A row is pushed when `in_valid` is high and the registered `count` is less than `depth`: `in_data` is written at `wr_ptr` and `wr_ptr` increments.
  - If `in_valid` is high while `count == depth`, the row is dropped, `overflow` is set, and the pointers and count are unchanged.
  - This rule holds even when a pop completes in the same cycle. There is no same-cycle slot reuse.
- **Serialize.**
  - `out_valid = !empty`.
  - `out_data` is the head row (at `rd_ptr`) sliced at word `idx`.
  - `out_col = idx`.
  - `out_last = out_valid && idx == col-1`.
- **Word handshake.** A word transfers on `out_valid && out_ready`.
  - If `idx < col-1`: `idx` increments.
  - If `idx == col-1`: `idx` returns to 0, `rd_ptr` increments, and the row is popped.
- **Count update.** `count` increments on push only, decrements on pop only, and is unchanged when a push and a pop happen in the same cycle.
- **Output behaviour.**
  - While empty, `out_data`, `out_col` and `out_last` are forced to 0.
  - While `out_valid` is high and `out_ready` is low, `out_data`, `out_col` and `out_last` hold stable.
- **Overflow.** Once set, `overflow` clears only on reset.
- **Ignored input.** The state of `out_ready` is ignored while empty.

## Timing
- **Reset** (`reset` low at an edge):
  - `count`, `wr_ptr`, `rd_ptr`, `idx` and `overflow` go to 0.
  - Outputs: `out_valid`=0, `out_data`=0, `out_col`=0, `out_last`=0, `empty`=1, `full`=0.
  - In-flight rows are discarded, including a partially drained head row.
  - `in_valid` is ignored during the reset cycle.
- **Latency.** A row sampled at edge N into an empty FIFO gives `out_valid`=1 with word 0 in the cycle after edge N. There is no combinational bypass from `in_data` to `out_data`.
- **Throughput.** With `out_ready` held high, one word transfers per cycle, so a row drains in `col` cycles. Back-to-back rows drain with no bubble.
- **Flags.** `full` and `empty` are derived from the registered `count` and change only on clock edges.
- **Pointer wrap.** `wr_ptr` and `rd_ptr` both wrap from depth-1 to 0. FIFO order is preserved across the wrap.

## Test plan
- **Reset values:** hold `reset` low for 2 cycles with `in_valid`=1 → all outputs 0 and `empty`=1 after release.
- **Single row:** push one row whose word k = 16'h0100+k, with `out_ready`=1 → starting the cycle after the push, `out_data` reads 0100..0107, `out_col` reads 0..7, and `out_last` is high only on 0107; then `empty`=1.
- **Backpressure:** push a row; toggle `out_ready` 1,0,0,1,... → a word advances only on cycles where `out_ready`=1, and `out_data` holds during the 0 cycles; exactly 8 transfers occur.
- **Overflow:** with `out_ready`=0, push 5 rows (tags 1..5) → `full`=1 after 4, the 5th is dropped and `overflow`=1. Then drain → rows 1..4 come out in order, `overflow` stays 1, and it clears only after reset.
- **Simultaneous push and pop at full:** with `full`=1, raise `in_valid` on the cycle of the head row's last-word handshake → the incoming row is dropped, `overflow`=1, and `count` becomes 3.
- **Wrap and reset mid-row:** stream 10 rows with random `out_ready` → all 80 words arrive in order, confirming pointer wrap. Then assert reset after 3 words of a row → `out_valid`=0 next cycle, and the next pushed row starts at `out_col`=0.

Source files
------------

// File: rtl/psum_row_serializer.sv
// psum_row_serializer: captures full-width psum rows from the accelerator core
// into a small row FIFO and streams them out one psum word per cycle over a
// ready/valid interface. The core cannot be stalled, so rows arriving while the
// FIFO is full are dropped and recorded in a sticky overflow flag.
module psum_row_serializer #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 4,
    localparam int col_w  = (col > 1) ? $clog2(col) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [psum_bw*col-1:0] in_data,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [psum_bw-1:0]     out_data,
    output logic [col_w-1:0]       out_col,
    output logic                   out_last,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = $clog2(depth + 1);

    localparam logic [cnt_w-1:0]   depth_c    = cnt_w'(depth);
    localparam logic [cnt_w-1:0]   cnt_zero_c = {cnt_w{1'b0}};
    localparam logic [cnt_w-1:0]   cnt_one_c  = {{(cnt_w-1){1'b0}}, 1'b1};
    localparam logic [col_w-1:0]   idx_zero_c = {col_w{1'b0}};
    localparam logic [col_w-1:0]   idx_one_c  = {{(col_w-1){1'b0}}, 1'b1};
    localparam logic [col_w-1:0]   last_col_c = col_w'(col - 1);
    localparam logic [ptr_w-1:0]   ptr_one_c  = {{(ptr_w-1){1'b0}}, 1'b1};
    localparam logic [psum_bw-1:0] word_zero_c = {psum_bw{1'b0}};

    // Extract psum word 'idx' from a full row (word k sits at bits [psum_bw*k +: psum_bw]).
    function automatic logic [psum_bw-1:0] word_at(
        input logic [psum_bw*col-1:0] row,
        input logic [col_w-1:0]       idx
    );
        return row[int'(idx)*psum_bw +: psum_bw];
    endfunction

    // Row storage and FIFO bookkeeping
    logic [psum_bw*col-1:0] mem_r [depth];
    logic [ptr_w-1:0]       wr_ptr_r;
    logic [ptr_w-1:0]       rd_ptr_r;
    logic [cnt_w-1:0]       count_r;
    logic [col_w-1:0]       idx_r;
    logic                   overflow_r;

    // Registered outputs
    logic                   out_valid_r;
    logic [psum_bw-1:0]     out_data_r;
    logic [col_w-1:0]       out_col_r;
    logic                   out_last_r;
    logic                   full_r;
    logic                   empty_r;

    // Next-state signals
    logic                   push_s;
    logic                   drop_s;
    logic                   xfer_s;
    logic                   pop_s;
    logic [ptr_w-1:0]       rd_ptr_nxt_s;
    logic [col_w-1:0]       idx_nxt_s;
    logic [cnt_w-1:0]       count_nxt_s;
    logic [psum_bw*col-1:0] head_nxt_s;

    // Decide push/drop/transfer/pop and compute the next pointer, column, count and head row.
    always_comb begin
        push_s       = in_valid && (count_r < depth_c);
        drop_s       = in_valid && (count_r == depth_c);
        xfer_s       = (count_r != cnt_zero_c) && out_ready;
        pop_s        = xfer_s && (idx_r == last_col_c);
        rd_ptr_nxt_s = rd_ptr_r;
        idx_nxt_s    = idx_r;
        count_nxt_s  = count_r;
        head_nxt_s   = mem_r[rd_ptr_r];

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + ptr_one_c;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (xfer_s) begin
            if (idx_r == last_col_c) begin
                idx_nxt_s = idx_zero_c;
            end else begin
                idx_nxt_s = idx_r + idx_one_c;
            end
        end else begin
            idx_nxt_s = idx_r;
        end

        if (push_s && !pop_s) begin
            count_nxt_s = count_r + cnt_one_c;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - cnt_one_c;
        end else begin
            count_nxt_s = count_r;
        end

        // When the pushed row will be the only row, it becomes the head directly;
        // otherwise the next head is already stored in the row array.
        if (push_s && (count_nxt_s == cnt_one_c)) begin
            head_nxt_s = in_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Write accepted rows into the row array; contents of free slots are never observed.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO state, sticky overflow and registered output presentation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r    <= {ptr_w{1'b0}};
            rd_ptr_r    <= {ptr_w{1'b0}};
            count_r     <= cnt_zero_c;
            idx_r       <= idx_zero_c;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= word_zero_c;
            out_col_r   <= idx_zero_c;
            out_last_r  <= 1'b0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_one_c;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            idx_r    <= idx_nxt_s;
            full_r   <= (count_nxt_s == depth_c);
            empty_r  <= (count_nxt_s == cnt_zero_c);
            if (count_nxt_s == cnt_zero_c) begin
                out_valid_r <= 1'b0;
                out_data_r  <= word_zero_c;
                out_col_r   <= idx_zero_c;
                out_last_r  <= 1'b0;
            end else begin
                out_valid_r <= 1'b1;
                out_data_r  <= word_at(head_nxt_s, idx_nxt_s);
                out_col_r   <= idx_nxt_s;
                out_last_r  <= (idx_nxt_s == last_col_c);
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_col   = out_col_r;
    assign out_last  = out_last_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_psum_row_serializer.sv
// Directed self-checking bench for psum_row_serializer (col=8, psum_bw=16, depth=4).
module tb_psum_row_serializer;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [BW*COL-1:0] in_data;
    logic              out_ready;
    logic              out_valid;
    logic [BW-1:0]     out_data;
    logic [2:0]        out_col;
    logic              out_last;
    logic              full;
    logic              empty;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    psum_row_serializer #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_col  (out_col),
        .out_last (out_last),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row whose word k equals base + k.
    function automatic logic [BW*COL-1:0] make_row(input logic [15:0] base);
        logic [BW*COL-1:0] r;
        for (int k = 0; k < COL; k++) begin
            r[k*BW +: BW] = base + 16'(k);
        end
        return r;
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    int e;
    int cyc;
    int pushed;
    int recv;
    logic acc;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = make_row(16'hdead);
        out_ready = 1'b1;

        // Reset values: held low two cycles with in_valid asserted.
        step();
        step();
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_empty", empty, 1'b1);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        check_val("rst_rel_valid", out_valid, 1'b0);
        check_val("rst_rel_data", out_data, 16'h0000);
        check_val("rst_rel_col", out_col, 3'd0);
        check_val("rst_rel_last", out_last, 1'b0);
        check_val("rst_rel_empty", empty, 1'b1);
        check_val("rst_rel_full", full, 1'b0);
        check_val("rst_rel_ovf", overflow, 1'b0);

        // Single row, out_ready high; no combinational bypass before the push edge.
        in_valid = 1'b1;
        in_data  = make_row(16'h0100);
        #1;
        check_val("single_nobypass_valid", out_valid, 1'b0);
        check_val("single_nobypass_data", out_data, 16'h0000);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < COL; k++) begin
            check_val("single_valid", out_valid, 1'b1);
            check_val("single_data", out_data, 32'h0100 + k);
            check_val("single_col", out_col, k);
            check_val("single_last", out_last, (k == COL - 1) ? 1'b1 : 1'b0);
            step();
        end
        check_val("single_empty", empty, 1'b1);
        check_val("single_valid_after", out_valid, 1'b0);
        check_val("single_data_after", out_data, 16'h0000);

        // Backpressure: out_ready pattern 1,0,0 repeating.
        in_valid = 1'b1;
        in_data  = make_row(16'h0200);
        step();
        in_valid = 1'b0;
        e   = 0;
        cyc = 0;
        while (e < COL && cyc < 60) begin
            out_ready = (cyc % 3 == 0) ? 1'b1 : 1'b0;
            check_val("bp_valid", out_valid, 1'b1);
            check_val("bp_data", out_data, 32'h0200 + e);
            check_val("bp_col", out_col, e);
            acc = out_ready;
            step();
            if (acc) e++;
            cyc++;
        end
        check_val("bp_transfers", e, COL);
        check_val("bp_cycles", cyc, 22);
        check_val("bp_empty", empty, 1'b1);

        // Overflow: five rows with out_ready low; the fifth is dropped.
        out_ready = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            in_valid = 1'b1;
            in_data  = make_row(16'(t << 8));
            step();
            if (t == 3) check_val("ovf_full3", full, 1'b0);
            if (t == 4) begin
                check_val("ovf_full4", full, 1'b1);
                check_val("ovf_flag4", overflow, 1'b0);
            end
        end
        in_valid = 1'b0;
        check_val("ovf_flag5", overflow, 1'b1);
        check_val("ovf_full5", full, 1'b1);
        out_ready = 1'b1;
        for (int w = 0; w < 4 * COL; w++) begin
            check_val("ovf_drain_data", out_data, ((w / COL + 1) << 8) + (w % COL));
            step();
        end
        check_val("ovf_drain_empty", empty, 1'b1);
        check_val("ovf_sticky", overflow, 1'b1);
        do_reset();
        check_val("ovf_cleared", overflow, 1'b0);

        // Push at full coinciding with the head row's last-word pop.
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            in_data  = make_row(16'h1100 + 16'(t << 8));
            step();
        end
        in_valid  = 1'b0;
        check_val("simul_full", full, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < COL - 1; k++) step();
        check_val("simul_last", out_last, 1'b1);
        check_val("simul_last_data", out_data, 16'h1107);
        in_valid = 1'b1;
        in_data  = make_row(16'h1500);
        step();
        in_valid = 1'b0;
        check_val("simul_ovf", overflow, 1'b1);
        check_val("simul_full_after", full, 1'b0);
        check_val("simul_head", out_data, 16'h1200);
        for (int w = 0; w < 3 * COL; w++) begin
            check_val("simul_drain_data", out_data, 32'h1200 + ((w / COL) << 8) + (w % COL));
            step();
        end
        check_val("simul_empty", empty, 1'b1);
        do_reset();

        // Ten rows with random out_ready: order preserved across pointer wrap.
        pushed = 0;
        recv   = 0;
        cyc    = 0;
        while (recv < 10 * COL && cyc < 800) begin
            in_valid  = (pushed < 10) && !full;
            in_data   = make_row(16'h3000 + 16'(pushed * 16));
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                check_val("wrap_data", out_data, 32'h3000 + (recv / COL) * 16 + (recv % COL));
                check_val("wrap_col", out_col, recv % COL);
                check_val("wrap_last", out_last, (recv % COL == COL - 1) ? 1'b1 : 1'b0);
                recv++;
            end
            acc = in_valid;
            step();
            if (acc) pushed++;
            cyc++;
        end
        in_valid = 1'b0;
        check_val("wrap_count", recv, 10 * COL);
        check_val("wrap_empty", empty, 1'b1);
        check_val("wrap_no_ovf", overflow, 1'b0);

        // Reset in the middle of a row drain.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = make_row(16'h4000);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check_val("midrst_pre_col", out_col, 3'd3);
        check_val("midrst_pre_data", out_data, 16'h4003);
        do_reset();
        check_val("midrst_valid", out_valid, 1'b0);
        check_val("midrst_empty", empty, 1'b1);
        in_valid = 1'b1;
        in_data  = make_row(16'h5000);
        step();
        in_valid = 1'b0;
        check_val("midrst_new_col", out_col, 3'd0);
        check_val("midrst_new_data", out_data, 16'h5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
